// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the 4-master round-robin bus arbiter.
// Grants are active-low, so ENABLE_/DISABLE_ name the pin levels rather than logic truth.
package bus_arbiter_pkg;

  localparam int BUS_OWNER_W      = 2;
  localparam int BUS_NUM_MASTERS  = 4;
  localparam int BUS_ARB_MAX_HOLD = 16;

  typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'h0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'h1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'h2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'h3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // The state encoding is the owner index, so the state register drives the owner port directly.
  typedef enum logic [BUS_OWNER_W-1:0] {
    OWNER0 = 2'h0,
    OWNER1 = 2'h1,
    OWNER2 = 2'h2,
    OWNER3 = 2'h3
  } owner_state_e;

  function automatic logic [BUS_NUM_MASTERS-1:0] grant_decode(input owner_state_e o);
    logic [BUS_NUM_MASTERS-1:0] g;
    g = {BUS_NUM_MASTERS{DISABLE_}};
    g[o] = ENABLE_;
    return g;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after the current owner.
// The same result is used when the owner releases and when its tenure expires.
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_OWNER_W-1:0]     owner,
  input  logic [BUS_NUM_MASTERS-1:0] req,
  output logic [BUS_OWNER_W-1:0]     next_owner,
  output logic                       valid
);

  logic [BUS_OWNER_W-1:0] cand;

  // Scan from farthest to nearest so that the nearest requester is the one kept.
  always_comb begin
    next_owner = owner;
    valid      = 1'b0;
    cand       = owner;
    for (int k = BUS_NUM_MASTERS - 1; k >= 1; k--) begin
      cand = owner + BUS_OWNER_W'(k);
      if (req[cand]) begin
        next_owner = cand;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 4-master shared bus with a bounded contended tenure.
// Owner, grants and preempt all come from flops updated by the same edge.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = BUS_ARB_MAX_HOLD,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       preempt
);

  // With MAX_HOLD == 0 the counter never expires and simply saturates at all-ones.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

  logic [BUS_NUM_MASTERS-1:0] req;
  logic                       owner_req;
  logic                       others;
  logic                       expired;
  logic [BUS_OWNER_W-1:0]     pick_owner;
  logic                       pick_valid;

  owner_state_e               state_q, state_d;
  logic [HOLD_W-1:0]          hold_cnt_q, hold_cnt_d;
  logic [BUS_NUM_MASTERS-1:0] grnt_q, grnt_d;
  logic                       preempt_q, preempt_d;

  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  bus_rr_pick u_pick (
    .owner      (state_q),
    .req        (req),
    .next_owner (pick_owner),
    .valid      (pick_valid)
  );

  always_comb begin
    owner_req  = req[state_q];
    others     = |(req & ~(4'b0001 << state_q));
    expired    = (MAX_HOLD != 0) && others && owner_req && (hold_cnt_q == HOLD_LAST);
    state_d    = state_q;
    hold_cnt_d = '0;
    preempt_d  = 1'b0;
    if (owner_req && !expired) begin
      if (others) begin
        hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
      end
    end else if (pick_valid) begin
      // Either a voluntary release or an expiry; expiry is flagged for one cycle.
      state_d   = owner_state_e'(pick_owner);
      preempt_d = expired;
    end
    grnt_d = grant_decode(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= OWNER0;
      hold_cnt_q <= '0;
      grnt_q     <= grant_decode(OWNER0);
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      grnt_q     <= grnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign owner    = state_q;
  assign m0_grnt_ = grnt_q[0];
  assign m1_grnt_ = grnt_q[1];
  assign m2_grnt_ = grnt_q[2];
  assign m3_grnt_ = grnt_q[3];
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a behavioural model pushes expected
// {preempt, grants, owner} per driven cycle; results are popped after each edge.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       preempt;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req_  (m0_req_),
    .m1_req_  (m1_req_),
    .m2_req_  (m2_req_),
    .m3_req_  (m3_req_),
    .m0_grnt_ (m0_grnt_),
    .m1_grnt_ (m1_grnt_),
    .m2_grnt_ (m2_grnt_),
    .m3_grnt_ (m3_grnt_),
    .owner    (owner),
    .preempt  (preempt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [6:0] exp_q[$];

  logic [1:0] m_owner;
  int         m_cnt;
  logic       m_pre;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_grants(input logic [1:0] o);
    logic [3:0] g;
    g    = 4'b1111;
    g[o] = 1'b0;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = 2'd0;
    m_cnt   = 0;
    m_pre   = 1'b0;
  endtask

  // Reference behaviour: rotation scan, hold counting, expiry after MAX_HOLD contended cycles.
  task automatic model_step(input logic [3:0] r);
    logic       oth;
    logic       found;
    logic [1:0] cand;
    oth = 1'b0;
    for (int i = 0; i < 4; i++) if (i != int'(m_owner) && r[i]) oth = 1'b1;
    if (r[m_owner] && !(oth && m_cnt == MAX_HOLD - 1)) begin
      m_cnt = oth ? m_cnt + 1 : 0;
      m_pre = 1'b0;
    end else if (oth) begin
      found = 1'b0;
      m_pre = r[m_owner];
      for (int k = 1; k < 4; k++) begin
        cand = m_owner + 2'(k);
        if (!found && r[cand]) begin
          found   = 1'b1;
          m_owner = cand;
        end
      end
      m_cnt = 0;
    end else begin
      m_cnt = 0;
      m_pre = 1'b0;
    end
  endtask

  // driver tasks
  task automatic drive_req(input logic [3:0] r);
    m0_req_ = ~r[0];
    m1_req_ = ~r[1];
    m2_req_ = ~r[2];
    m3_req_ = ~r[3];
  endtask

  task automatic step(input logic [3:0] r);
    logic [6:0] e;
    @(negedge clk);
    drive_req(r);
    model_step(r);
    exp_q.push_back({m_pre, m_grants(m_owner), m_owner});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("owner",   32'(owner), 32'(e[1:0]));
    check("grants",  32'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 32'(e[5:2]));
    check("preempt", 32'(preempt), 32'(e[6]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_req(4'b0000);
    #1;
    check("rst_owner",   32'(owner), 32'd0);
    check("rst_grants",  32'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 32'hE);
    check("rst_preempt", 32'(preempt), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  logic [3:0] req;
  int         held;
  logic [1:0] prev_obs;
  logic [1:0] seq[$];
  int         gcyc;
  int         pcount;

  initial begin
    reset = 1'b1;
    drive_req(4'b0000);
    model_reset();
    #2;

    // 1: parked on master 0 with no requests
    do_reset();
    repeat (50) step(4'b0000);

    // 2: request from idle bus is granted on the next cycle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step((i >= 5) ? 4'b0100 : 4'b0000);
      if (i == 5) begin
        check("t2_owner",  32'(owner), 32'd2);
        check("t2_grants", 32'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 32'hB);
      end
    end

    // 3: three simultaneous requesters rotate 1,2,3 without gaps
    do_reset();
    req  = 4'b1110;
    held = 0;
    seq.delete();
    for (int i = 0; i < 16; i++) begin
      logic [1:0] prev_m;
      prev_m   = m_owner;
      prev_obs = owner;
      if (m_owner != 2'd0 && req[m_owner] && held == 3) req[m_owner] = 1'b0;
      step(req);
      held = (m_owner != prev_m) ? 1 : held + 1;
      if (owner != prev_obs) seq.push_back(owner);
    end
    check("t3_seq_len", 32'(seq.size()), 32'd3);
    while (seq.size() < 3) seq.push_back(2'd0);
    check("t3_seq0", 32'(seq[0]), 32'd1);
    check("t3_seq1", 32'(seq[1]), 32'd2);
    check("t3_seq2", 32'(seq[2]), 32'd3);

    // 4: hold expiry preempts master 0 after 16 contended cycles
    do_reset();
    req    = 4'b0001;
    held   = 0;
    gcyc   = -1;
    pcount = 0;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] prev_m;
      prev_m = m_owner;
      if (i == 10) req[3] = 1'b1;
      if (m_owner == 2'd3 && held == 3) req[3] = 1'b0;
      step(req);
      held = (m_owner != prev_m) ? 1 : held + 1;
      if (owner == 2'd3 && gcyc < 0) gcyc = i + 1;
      if (preempt === 1'b1) pcount++;
    end
    check("t4_grant_cycle", 32'(gcyc), 32'd26);
    check("t4_preempt_cnt", 32'(pcount), 32'd1);
    check("t4_owner_back",  32'(owner), 32'd0);

    // 5: release by owner 3 wraps around to master 0
    do_reset();
    step(4'b1000);
    step(4'b1000);
    step(4'b0011);
    check("t5_wrap_owner", 32'(owner), 32'd0);

    // 6: asynchronous reset in the middle of a contended tenure of master 2
    do_reset();
    step(4'b0100);
    repeat (10) step(4'b1100);
    check("t6_pre_owner", 32'(owner), 32'd2);
    do_reset();
    repeat (20) step(4'b0011);

    // random traffic with sticky requests so expiries do occur
    do_reset();
    req = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      step(req);
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
